// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith, bit-serial shifts, shift-and-add multiply.
// Define ALU_MUL_EN to build op 15 as the iterative multiplier; otherwise op 15 is a NOP.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             flags_load,
  input  logic [3:0]       flags_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  typedef enum logic [3:0] {
    OP_NOP, OP_NOT, OP_PASSA, OP_PASSB, OP_INC, OP_DEC, OP_ADD, OP_SUB,
    OP_AND, OP_OR, OP_SHL, OP_SHR, OP_SETC, OP_CLRC, OP_ADC, OP_MUL
  } op_t;

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] shReg;
  logic             shLeft;

  op_t              opc;
  logic [SHW-1:0]   shAmt;
  logic             isShift;

  assign opc      = op_t'(op);
  assign shAmt    = b[SHW-1:0];
  assign isShift  = ((opc == OP_SHL) || (opc == OP_SHR)) && (shAmt != '0);
  assign in_ready = (state == IDLE) && !flush;

  logic [WIDTH:0]   sum;
  logic             v, arith, logicOp;
  logic [WIDTH-1:0] sRes;
  logic [3:0]       sFlags;

  always_comb begin
    sum     = '0;
    v       = 1'b0;
    arith   = 1'b0;
    logicOp = 1'b0;
    sRes    = '0;
    sFlags  = flags;
    case (opc)
      OP_NOT:   begin sRes = ~a;    logicOp = 1'b1; end
      OP_PASSA: begin sRes = a;     logicOp = 1'b1; end
      OP_PASSB: begin sRes = b;     logicOp = 1'b1; end
      OP_AND:   begin sRes = a & b; logicOp = 1'b1; end
      OP_OR:    begin sRes = a | b; logicOp = 1'b1; end
      OP_INC: begin
        sum   = {1'b0, a} + (WIDTH+1)'(1);
        v     = ~a[WIDTH-1] & sum[WIDTH-1];
        arith = 1'b1;
      end
      OP_DEC: begin
        sum   = {1'b0, a} - (WIDTH+1)'(1);
        v     = a[WIDTH-1] & ~sum[WIDTH-1];
        arith = 1'b1;
      end
      OP_ADD, OP_ADC: begin
        sum   = {1'b0, a} + {1'b0, b} + ((opc == OP_ADC) ? (WIDTH+1)'(flags[2]) : '0);
        v     = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        arith = 1'b1;
      end
      OP_SUB: begin
        sum   = {1'b0, a} - {1'b0, b};
        v     = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        arith = 1'b1;
      end
      // Only reached for a zero shift amount: pass a through, keep C.
      OP_SHL, OP_SHR: begin
        sRes   = a;
        sFlags = {1'b0, flags[2], a[WIDTH-1], ~|a};
      end
      OP_SETC: sFlags[2] = 1'b1;
      OP_CLRC: sFlags[2] = 1'b0;
      default: ;
    endcase
    if (arith) begin
      sRes   = sum[WIDTH-1:0];
      sFlags = {v, sum[WIDTH], sum[WIDTH-1], ~|sum[WIDTH-1:0]};
    end
    if (logicOp)
      sFlags = {flags[3:2], sRes[WIDTH-1], ~|sRes};
  end

  // One shift step; the accept edge itself performs the first step.
  logic [WIDTH-1:0] stepIn, stepVal;
  logic             stepLeft, stepC;
  logic [3:0]       shFlags;

  always_comb begin
    stepIn   = (state == IDLE) ? a : shReg;
    stepLeft = (state == IDLE) ? (opc == OP_SHL) : shLeft;
    stepVal  = stepLeft ? {stepIn[WIDTH-2:0], 1'b0} : {1'b0, stepIn[WIDTH-1:1]};
    stepC    = stepLeft ? stepIn[WIDTH-1] : stepIn[0];
    shFlags  = {1'b0, stepC, stepVal[WIDTH-1], ~|stepVal};
  end

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] acc, mcd, accNext;
  logic [WIDTH-1:0]   mpl, mulLo;
  logic               mulHi;

  assign accNext = acc + (mpl[0] ? mcd : '0);
  assign mulLo   = accNext[WIDTH-1:0];
  assign mulHi   = |accNext[2*WIDTH-1:WIDTH];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      shReg     <= '0;
      shLeft    <= 1'b0;
      result    <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
`ifdef ALU_MUL_EN
      acc       <= '0;
      mcd       <= '0;
      mpl       <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (in_valid) begin
            if (isShift) begin
              shReg  <= stepVal;
              shLeft <= (opc == OP_SHL);
              cnt    <= shAmt - SHW'(1);
              if (shAmt == SHW'(1)) begin
                result    <= stepVal;
                flags     <= shFlags;
                out_valid <= 1'b1;
              end else begin
                state <= SHIFT;
              end
            end
`ifdef ALU_MUL_EN
            else if (opc == OP_MUL) begin
              acc   <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
              mcd   <= {{(WIDTH-1){1'b0}}, a, 1'b0};
              mpl   <= b >> 1;
              cnt   <= SHW'(WIDTH - 1);
              state <= MUL;
            end
`endif
            else begin
              result    <= sRes;
              flags     <= sFlags;
              out_valid <= 1'b1;
            end
          end
          SHIFT: begin
            shReg <= stepVal;
            cnt   <= cnt - SHW'(1);
            if (cnt == SHW'(1)) begin
              result    <= stepVal;
              flags     <= shFlags;
              out_valid <= 1'b1;
              state     <= IDLE;
            end
          end
`ifdef ALU_MUL_EN
          MUL: begin
            acc <= accNext;
            mcd <= mcd << 1;
            mpl <= mpl >> 1;
            cnt <= cnt - SHW'(1);
            if (cnt == SHW'(1)) begin
              result    <= mulLo;
              flags     <= {mulHi, mulHi, mulLo[WIDTH-1], ~|mulLo};
              out_valid <= 1'b1;
              state     <= IDLE;
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end
      if (flags_load)
        flags <= flags_in;
    end
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential ALU for the MZNM execute stage. Single-cycle logic and arithmetic ops complete in one cycle; shifts run one bit position per cycle and multiply runs shift-and-add, both behind a valid/ready handshake. Z/N/C/V are held in an internal flag register with per-op update rules and a restore path for interrupt return.

## Interface
- WIDTH, 16: operand and result width; must be ≥ 4.
- SHW, $clog2(WIDTH)+1: width of the shift-amount field, taken from `b[SHW-1:0]`.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  op/a/b valid this cycle.
- in_ready  out  1  block can accept an op this cycle.
- op  in  4  opcode: 0 NOP, 1 NOT, 2 PASSA, 3 PASSB, 4 INC, 5 DEC, 6 ADD, 7 SUB, 8 AND, 9 OR, 10 SHL, 11 SHR, 12 SETC, 13 CLRC, 14 ADC, 15 MUL.
- a  in  WIDTH  first operand (Rdst).
- b  in  WIDTH  second operand (Rsrc or shift amount).
- flush  in  1  abort any in-flight op.
- flags_load  in  1  overwrite the flag register from flags_in.
- flags_in  in  4  {V,C,N,Z} restore value.
- out_valid  out  1  one-cycle pulse: result and flags are updated.
- result  out  WIDTH  last completed result; holds between completions.
- flags  out  4  {V,C,N,Z} flag register.

## Operation
- States: IDLE, SHIFT, MUL. `in_ready` = (state == IDLE) && !flush.
- Accept = in_valid && in_ready. Ops 0–9, 12–14, and shifts with amount 0 finish from IDLE. SHL/SHR with amount n ≥ 1 go to SHIFT; MUL goes to MUL.
- Arithmetic is done at WIDTH+1 bits; bit WIDTH is the carry-out.
  - INC: a+1. DEC: a−1. ADD: a+b. ADC: a+b+C.
  - SUB: a−b. C is set to the borrow, i.e. 1 when a < b unsigned.
  - V for add-class ops: a and b have the same sign and the result sign differs.
  - V for SUB/DEC: a and b have different signs and the result sign differs from a.
- Flag updates:
  - Arithmetic ops update Z, N, C, V.
  - NOT, AND, OR, PASSA, PASSB update Z and N only.
  - SETC sets C=1; CLRC sets C=0. Both give result 0 and leave Z, N, V unchanged.
  - NOP gives result 0 and leaves all flags unchanged.
- SHIFT:
  - The counter is loaded with n = b[SHW-1:0]. The operand moves one position per cycle (SHL toward the MSB, SHR toward the LSB, zero fill); C takes the bit shifted out.
  - The op completes when the counter reaches 0.
  - n > WIDTH gives result 0 and C=0.
  - Z and N update from the result, V=0.
  - Amount 0 gives result a with C unchanged.
- MUL:
  - Runs WIDTH iterations of shift-and-add into a 2·WIDTH accumulator; result is the low WIDTH bits.
  - C = V = 1 when the high half is nonzero, else 0. Z and N come from the low half.
- flush returns the block to IDLE from any state. It produces no out_valid and leaves flags and result unchanged. An op presented in the flush cycle is not accepted.
- flags_load has priority over a flag update completing in the same cycle; result and out_valid still update.
- Reset: state IDLE, result 0, flags 0, out_valid 0, counter 0, accumulator 0. Reset during SHIFT or MUL discards the op.

## Timing
- Accept in cycle k:
  - Single-cycle op: out_valid high in cycle k+1. in_ready stays high, so back-to-back ops run at one per cycle.
  - Shift with n ≥ 1: out_valid in cycle k+n; in_ready is low for cycles k+1 … k+n−1 and high again in cycle k+n.
  - MUL: out_valid in cycle k+WIDTH; in_ready is low for cycles k+1 … k+WIDTH−1.
- result and flags are registered and change only at the edge that raises out_valid, or at a flags_load edge for flags.
- No output backpressure: the consumer must sample the result during the out_valid cycle.

## Configuration
- ALU_MUL_EN defined: op 15 is the iterative multiplier described above.
- ALU_MUL_EN undefined: the MUL state, accumulator and adder are not compiled. Op 15 behaves exactly as NOP: single cycle, result 0, flags unchanged.

## Test plan
- ADD 0x7FFF + 0x0001 (WIDTH=16) → cycle k+1: result 0x8000, flags V=1 C=0 N=1 Z=0. Then SUB 0x0003 − 0x0005 → 0xFFFE with C=1 N=1 V=0.
- SHL a=0x8001 b=1 → k+1: 0x0002, C=1. SHL a=0x0001 b=4 → in_ready low in k+1…k+3, out_valid in k+4 with result 0x0010, C=0. SHR a=0x0001 b=0 → k+1: 0x0001, C unchanged.
- SETC, then ADC a=0x0001 b=0x0001 → 0x0003, C=0. SHR a=0xFFFF b=20 → k+20: result 0, Z=1, C=0.
- MUL 0x0100 × 0x0100 → out_valid in k+16 with result 0x0000, Z=1 C=1 V=1. With ALU_MUL_EN undefined → k+1: result 0, flags unchanged.
- SHR b=10 accepted, flush in cycle k+3 → no out_valid, in_ready high in k+4, flags and result unchanged. Assert rst mid-MUL → all outputs 0 in the same cycle.
- flags_load with flags_in=4'b1010 in the same cycle an ADD completes → flags=4'b1010, result updated, out_valid=1.
